// File: rtl/pdm_capture_pkg.sv
// pdm_capture_pkg: capture FSM state encoding and default geometry shared by the PDM capture block.
package pdm_capture_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} cap_state_t;
    localparam int DEF_CLK_DIV = 100;
    localparam int DEF_WORD_W  = 16;
endpackage

// File: rtl/pdm_word_packer.sv
// pdm_word_packer: shifts PDM bits MSB-first into a word and flags each completed word for one cycle.
module pdm_word_packer
    import pdm_capture_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              sample_tick,
    input  logic              data_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);
    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] B_LAST = BW'(WORD_W - 1);
    logic [WORD_W-1:0] r_sh, r_word, w_sh;
    logic [BW-1:0]     r_bit;
    logic              r_valid, w_last;
    assign w_sh       = {r_sh[WORD_W-2:0], data_in};
    assign w_last     = sample_tick && r_bit == B_LAST;
    assign word_valid = r_valid;
    assign word       = r_word;
    // clr drops a partial word but keeps the last completed word visible
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sh    <= '0;
            r_word  <= '0;
            r_bit   <= '0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_sh    <= '0;
            r_bit   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (sample_tick) begin
                r_sh  <= w_sh;
                r_bit <= w_last ? '0 : r_bit + 1'b1;
            end
            if (w_last) r_word <= w_sh;
        end
    end
endmodule

// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: drives the PDM mic clock, discards wake-up samples and writes packed words to RAM.
// Define REC_LOOP_EN to record into a circular buffer instead of stopping in DONE when full.
module pdm_capture_ctrl #(
    parameter int CLK_DIV   = pdm_capture_pkg::DEF_CLK_DIV,
    parameter int WORD_W    = pdm_capture_pkg::DEF_WORD_W,
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 16384,
    parameter int SETTLE    = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pdm_data_i,
    output logic              pdm_clk_o,
    output logic              pdm_lrsel_o,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);
    import pdm_capture_pkg::cap_state_t;
    import pdm_capture_pkg::IDLE;
    import pdm_capture_pkg::CAPTURE;
    import pdm_capture_pkg::DONE;
    localparam cap_state_t S_SETTLE = pdm_capture_pkg::SETTLE;
    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int CW = ADDR_W + 1;
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] D_TICK = DW'(CLK_DIV / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);
    cap_state_t        r_state, w_nxt;
    logic [DW-1:0]     r_div, w_div_nxt;
    logic [SW-1:0]     r_settle;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_pdm_clk, w_busy, w_run_nxt, w_tick, w_clear, w_we, w_done;
    assign w_busy    = r_state == S_SETTLE || r_state == CAPTURE;
    assign w_run_nxt = w_nxt == S_SETTLE || w_nxt == CAPTURE;
    assign w_tick    = w_busy && r_div == D_TICK;
    assign w_clear   = !w_busy && w_nxt == S_SETTLE;
    // divider restarts from 0 on every entry so the first mic period is full length
    assign w_div_nxt = (w_busy && w_run_nxt && r_div != D_LAST) ? r_div + 1'b1 : '0;
`ifdef REC_LOOP_EN
    localparam logic [CW-1:0]     C_MAX  = CW'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(MAX_WORDS - 1);
    logic w_wrap;
    assign w_wrap      = w_we && r_addr == A_LAST;
    assign full        = w_wrap;
    assign w_count_nxt = r_count == C_MAX ? r_count : r_count + 1'b1;
    assign w_addr_nxt  = w_wrap ? '0 : r_addr + 1'b1;
    assign w_done      = 1'b0;
`else
    localparam logic [CW-1:0] C_LAST = CW'(MAX_WORDS - 1);
    assign full        = r_state == DONE;
    assign w_count_nxt = r_count + 1'b1;
    assign w_addr_nxt  = r_addr + 1'b1;
    assign w_done      = w_we && r_count == C_LAST;
`endif
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:     w_nxt = (start && !stop) ? S_SETTLE : IDLE;
            S_SETTLE: w_nxt = stop ? IDLE : (w_tick && r_settle == S_LAST) ? CAPTURE : S_SETTLE;
            CAPTURE:  w_nxt = stop ? IDLE : w_done ? DONE : CAPTURE;
            default:  w_nxt = stop ? IDLE : start ? S_SETTLE : DONE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_pdm_clk <= 1'b0;
            r_settle  <= '0;
            r_count   <= '0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_nxt;
            r_div     <= w_div_nxt;
            r_pdm_clk <= w_run_nxt && w_div_nxt <= D_TICK;
            if (w_clear) begin
                r_settle <= '0;
                r_count  <= '0;
                r_addr   <= '0;
            end else begin
                if (w_tick && r_state == S_SETTLE) r_settle <= r_settle + 1'b1;
                if (w_we) begin
                    r_count <= w_count_nxt;
                    r_addr  <= w_addr_nxt;
                end
            end
        end
    end
    // stop on the completing tick clears the packer so that word is never written
    pdm_word_packer #(.WORD_W(WORD_W)) u_packer (
        .clock       (clock),
        .reset_n     (reset_n),
        .clr         (r_state != CAPTURE || stop),
        .sample_tick (w_tick),
        .data_in     (pdm_data_i),
        .word_valid  (w_we),
        .word        (mem_wdata)
    );
    assign pdm_clk_o   = r_pdm_clk;
    assign pdm_lrsel_o = 1'b0;
    assign mem_we      = w_we;
    assign mem_addr    = r_addr;
    assign busy        = w_busy;
    assign word_count  = r_count;
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb_pdm_capture_ctrl: directed capture scenarios with a write scoreboard on the memory port.
module tb_pdm_capture_ctrl;
    localparam int AW = 14;
    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, pdm_data = 1'b0;
    logic pdm_clk, lrsel, mem_we, busy, full;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic [AW+15:0] exp_q[$];
    logic [AW+15:0] e_wr;
    int n_chk = 0, n_pass = 0, n_full = 0;

    always #5 clock = ~clock;

    pdm_capture_ctrl #(.CLK_DIV(4), .WORD_W(16), .ADDR_W(AW), .MAX_WORDS(4), .SETTLE(2)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .pdm_data_i(pdm_data),
        .pdm_clk_o(pdm_clk), .pdm_lrsel_o(lrsel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .full(full), .word_count(word_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // scoreboard: every write must match the oldest expected (addr, data)
    always @(negedge clock) if (reset_n) begin
        if (full) n_full++;
        if (mem_we) begin
            if (exp_q.size() == 0) check("unexpected_write", {16'h0, mem_wdata}, 32'hFFFF_FFFF);
            else begin
                e_wr = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e_wr[AW+15:16]));
                check("wr_data", 32'(mem_wdata), 32'(e_wr[15:0]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic next_rise();
        logic prev;
        bit got;
        prev = pdm_clk;
        got = 0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clock);
            got = pdm_clk && !prev;
            prev = pdm_clk;
        end
        if (!got) check("pdm_clk_rise", 32'(got), 32'd1);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            next_rise();
            pdm_data = v[i];
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic [AW-1:0] a);
        send_bits(w, 16);
        exp_q.push_back({a, w});
    endtask

    task automatic begin_capture();
        start = 1'b1;
        next_rise();
        start = 1'b0;
        pdm_data = 1'b1;
        next_rise();
        pdm_data = 1'b0;
    endtask

    initial begin
        cyc(2);
        check("rst_pdm_clk", 32'(pdm_clk), 0);
        check("rst_lrsel", 32'(lrsel), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(word_count), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        reset_n = 1'b1;
        cyc(3);
        check("idle_pdm_clk", 32'(pdm_clk), 0);

        begin_capture();
        check("settle_busy", 32'(busy), 1);
        send_word(16'hA5C3, 0);
        cyc(1);
        check("tick_cycle_we", 32'(mem_we), 0);
        cyc(1);
        check("latency_we", 32'(mem_we), 1);
        check("latency_addr", 32'(mem_addr), 0);
        check("latency_data", 32'(mem_wdata), 32'hA5C3);
        cyc(1);
        check("first_count", 32'(word_count), 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_pdm_clk", 32'(pdm_clk), 0);

        begin_capture();
        send_word(16'h1234, 0);
        send_bits(16'h0055, 7);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(8);
        check("partial_count", 32'(word_count), 1);
        check("partial_busy", 32'(busy), 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart_count", 32'(word_count), 0);
        check("restart_busy", 32'(busy), 1);
        next_rise();
        send_bits(16'hBEEF, 16);
        cyc(1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_on_tick_we", 32'(mem_we), 0);
        cyc(4);
        check("stop_on_tick_count", 32'(word_count), 0);

`ifdef REC_LOOP_EN
        n_full = 0;
        begin_capture();
        for (int w = 0; w < 6; w++) send_word(16'h0010 + 16'(w), AW'(w % 4));
        cyc(3);
        check("loop_full_pulses", 32'(n_full), 1);
        check("loop_busy", 32'(busy), 1);
        check("loop_count_sat", 32'(word_count), 4);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
`else
        begin_capture();
        for (int w = 1; w <= 4; w++) send_word(16'(w), AW'(w - 1));
        cyc(3);
        check("done_full", 32'(full), 1);
        check("done_busy", 32'(busy), 0);
        check("done_count", 32'(word_count), 4);
        check("done_pdm_clk", 32'(pdm_clk), 0);
        cyc(12);
        check("done_hold_full", 32'(full), 1);
        check("done_hold_count", 32'(word_count), 4);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("rearm_full", 32'(full), 0);
        check("rearm_count", 32'(word_count), 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
`endif

        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        check("start_stop_busy", 32'(busy), 0);
        cyc(3);
        check("start_stop_pdm_clk", 32'(pdm_clk), 0);
        start = 1'b0;
        stop = 1'b0;

        begin_capture();
        send_word(16'hF00F, 0);
        send_bits(16'h0015, 5);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_count", 32'(word_count), 0);
        check("async_rst_addr", 32'(mem_addr), 0);
        check("async_rst_wdata", 32'(mem_wdata), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_pdm_clk", 32'(pdm_clk), 0);
        cyc(1);
        check("async_rst_we", 32'(mem_we), 0);
        reset_n = 1'b1;
        cyc(2);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
